// File: rtl/irq_pend_arbiter_pkg.sv
// irq_pend_arbiter_pkg: shared defaults and FSM state encoding for the interrupt arbiter
package irq_pend_arbiter_pkg;
    localparam int NIRQ_DEF     = 3;
    localparam int NBIT_IRQ_DEF = 2;
    localparam int IRQ_ST_NBIT  = 2;
    typedef enum logic [IRQ_ST_NBIT-1:0] {
        IRQ_ST_IDLE = 2'd0,
        IRQ_ST_REQ  = 2'd1,
        IRQ_ST_SERV = 2'd2
    } irq_st_e;
endpackage

// File: rtl/irq_pend_arbiter_if.sv
// irq_pend_arbiter_if: request/handshake bundle between the arbiter and the ID/commit stages
interface irq_pend_arbiter_if
    import irq_pend_arbiter_pkg::*;
#(
    parameter int NIRQ     = NIRQ_DEF,
    parameter int NBIT_IRQ = NBIT_IRQ_DEF
);
    logic                ack;
    logic                eret;
    logic                ivld;
    logic [NBIT_IRQ-1:0] inum;
    logic [NIRQ-1:0]     pending;
    logic [NIRQ-1:0]     isr;
    logic                busy;
    modport master (output ack, eret, input ivld, inum, pending, isr, busy);
    modport slave  (input ack, eret, output ivld, inum, pending, isr, busy);
endinterface

// File: rtl/irq_edge_sync.sv
// irq_edge_sync: two-flop synchroniser followed by a one-cycle rising-edge pulse
module irq_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);
    logic [2:0] sh;
    // sh[1:0] synchronise, sh[2] remembers the previous synchronised level
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sh <= '0;
        else        sh <= {sh[1:0], async_in};
    assign rise_pulse = sh[1] & ~sh[2];
endmodule

// File: rtl/irq_pend_arbiter.sv
// irq_pend_arbiter: latches interrupt edges, presents the highest-priority one and tracks ack/eret; IRQ_NEST_EN enables nested preemption
module irq_pend_arbiter
    import irq_pend_arbiter_pkg::*;
#(
    parameter int NIRQ     = NIRQ_DEF,
    parameter int NBIT_IRQ = NBIT_IRQ_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NIRQ-1:0] irq_src,
    irq_pend_arbiter_if.slave bus
);
    function automatic logic [NBIT_IRQ-1:0] prio_enc(input logic [NIRQ-1:0] v);
        prio_enc = '0;
        for (int i = 0; i < NIRQ; i++)
            if (v[i]) prio_enc = NBIT_IRQ'(i);
    endfunction

    irq_st_e             state, state_nxt;
    logic [NIRQ-1:0]     rise, pending, isr, isr_pop, inum_mask;
    logic [NBIT_IRQ-1:0] inum;
    logic                do_ack, do_eret, enter_req;

    for (genvar g = 0; g < NIRQ; g++) begin : g_sync
        irq_edge_sync u_sync (
            .clk        (clk),
            .rst_n      (rst_n),
            .async_in   (irq_src[g]),
            .rise_pulse (rise[g])
        );
    end

    assign do_ack    = en && state == IRQ_ST_REQ && bus.ack;
    assign do_eret   = en && state == IRQ_ST_SERV && bus.eret;
    assign inum_mask = NIRQ'(1) << inum;
    assign isr_pop   = isr & ~(NIRQ'(1) << prio_enc(isr));
    assign enter_req = state_nxt == IRQ_ST_REQ && state != IRQ_ST_REQ;
`ifdef IRQ_NEST_EN
    logic nest_req;
    assign nest_req = |pending && prio_enc(pending) > prio_enc(isr);
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IRQ_ST_IDLE;
        else        state <= state_nxt;

    // next state; ack has priority over eret because eret only matters in SERV
    always_comb begin
        state_nxt = state;
        case (state)
            IRQ_ST_IDLE: state_nxt = |pending ? IRQ_ST_REQ : IRQ_ST_IDLE;
            IRQ_ST_REQ:  state_nxt = bus.ack ? IRQ_ST_SERV : IRQ_ST_REQ;
`ifdef IRQ_NEST_EN
            IRQ_ST_SERV: state_nxt = bus.eret ? (|isr_pop ? IRQ_ST_SERV : IRQ_ST_IDLE)
                                              : (nest_req ? IRQ_ST_REQ : IRQ_ST_SERV);
`else
            IRQ_ST_SERV: state_nxt = bus.eret ? IRQ_ST_IDLE : IRQ_ST_SERV;
`endif
            default:     state_nxt = IRQ_ST_IDLE;
        endcase
        if (!en) state_nxt = state;
    end

    // request valid is a pure decode of the REQ state
    always_comb bus.ivld = state == IRQ_ST_REQ;

    // pending keeps capturing during a stall; a fresh edge beats a same-cycle ack clear
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pending <= '0;
        else        pending <= (pending & ~(do_ack ? inum_mask : '0)) | rise;

    // inum is frozen for the whole REQ visit
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)         inum <= '0;
        else if (enter_req) inum <= prio_enc(pending);

    // in-service mask: ack pushes the presented source, eret pops the highest one
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)       isr <= '0;
        else if (do_ack)  isr <= isr | inum_mask;
        else if (do_eret) isr <= isr_pop;

    assign bus.inum    = inum;
    assign bus.pending = pending;
    assign bus.isr     = isr;
    assign bus.busy    = |isr;
endmodule

// File: tb/tb_irq_pend_arbiter.sv
// tb_irq_pend_arbiter: directed stimulus with a request scoreboard for irq_pend_arbiter
module tb_irq_pend_arbiter;
    import irq_pend_arbiter_pkg::*;
    localparam int NIRQ = 3;
    localparam int NB   = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b1;
    logic [NIRQ-1:0] irq_src = '0;

    irq_pend_arbiter_if #(.NIRQ(NIRQ), .NBIT_IRQ(NB)) bus ();

    irq_pend_arbiter #(.NIRQ(NIRQ), .NBIT_IRQ(NB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .irq_src (irq_src),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         nm;
        logic [NB-1:0] inum;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    int            n_cmp = 0;
    int            n_bad = 0;
    logic          ivld_q = 1'b0;
    logic [NB-1:0] inum_q = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [NIRQ-1:0] v);
        irq_src = v;
        cyc(1);
        irq_src = '0;
    endtask

    // monitor: every new request presented to ID must match the oldest expected one
    always @(negedge clk) begin
        if (!rst_n) begin
            ivld_q <= 1'b0;
        end else begin
            if (bus.ivld && !ivld_q) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ivld: got inum %0d expected no request (t=%0t)", bus.inum, $time);
                end else begin
                    e = sb.pop_front();
                    chk({e.nm, "_inum"}, 32'(bus.inum), 32'(e.inum));
                end
            end
            if (bus.ivld && ivld_q) chk("inum_stable", 32'(bus.inum), 32'(inum_q));
            ivld_q <= bus.ivld;
            inum_q <= bus.inum;
        end
    end

    initial begin
        bus.ack  = 1'b0;
        bus.eret = 1'b0;
        // 1: reset held, sources toggling
        for (int i = 1; i <= 4; i++) begin
            irq_src = 3'(i);
            cyc(1);
            chk("rst_ivld", 32'(bus.ivld), 0);
            chk("rst_pending", 32'(bus.pending), 0);
            chk("rst_isr", 32'(bus.isr), 0);
        end
        chk("rst_inum", 32'(bus.inum), 0);
        irq_src = '0;
        cyc(1);
        rst_n = 1'b1;
        cyc(4);
        // 2: single source, latency and full handshake
        irq_src = 3'b010;
        sb.push_back('{"t2", 2'd1});
        cyc(3);
        chk("t2_pending_e2", 32'(bus.pending), 32'b010);
        chk("t2_ivld_e2", 32'(bus.ivld), 0);
        irq_src = '0;
        cyc(1);
        chk("t2_ivld_e3", 32'(bus.ivld), 1);
        bus.ack = 1'b1;
        cyc(1);
        bus.ack = 1'b0;
        chk("t2_pending_ack", 32'(bus.pending), 0);
        chk("t2_isr_ack", 32'(bus.isr), 32'b010);
        chk("t2_busy_ack", 32'(bus.busy), 1);
        chk("t2_ivld_ack", 32'(bus.ivld), 0);
        bus.eret = 1'b1;
        cyc(1);
        bus.eret = 1'b0;
        chk("t2_isr_eret", 32'(bus.isr), 0);
        chk("t2_busy_eret", 32'(bus.busy), 0);
        cyc(2);
        chk("t2_idle_ivld", 32'(bus.ivld), 0);
        // 3: simultaneous edges, priority order
        sb.push_back('{"t3_hi", 2'd2});
        sb.push_back('{"t3_lo", 2'd0});
        pulse(3'b101);
        cyc(2);
        chk("t3_pending", 32'(bus.pending), 32'b101);
        cyc(1);
        chk("t3_ivld", 32'(bus.ivld), 1);
        bus.ack = 1'b1;
        cyc(1);
        bus.ack = 1'b0;
        chk("t3_pending_ack", 32'(bus.pending), 32'b001);
        chk("t3_isr_ack", 32'(bus.isr), 32'b100);
        bus.eret = 1'b1;
        cyc(1);
        bus.eret = 1'b0;
        chk("t3_isr_eret", 32'(bus.isr), 0);
        cyc(1);
        chk("t3_ivld_lo", 32'(bus.ivld), 1);
        bus.ack = 1'b1;
        cyc(1);
        bus.ack = 1'b0;
        bus.eret = 1'b1;
        cyc(1);
        bus.eret = 1'b0;
        chk("t3_isr_done", 32'(bus.isr), 0);
        // 4: edge coincident with ack, then stall during REQ
        sb.push_back('{"t4_a", 2'd1});
        pulse(3'b010);
        cyc(3);
        chk("t4_ivld", 32'(bus.ivld), 1);
        irq_src = 3'b010;
        cyc(1);
        irq_src = '0;
        cyc(1);
        bus.ack = 1'b1;
        cyc(1);
        bus.ack = 1'b0;
        chk("t4_set_wins", 32'(bus.pending), 32'b010);
        chk("t4_isr", 32'(bus.isr), 32'b010);
        sb.push_back('{"t4_b", 2'd1});
        bus.eret = 1'b1;
        cyc(1);
        bus.eret = 1'b0;
        cyc(1);
        chk("t4_rereq", 32'(bus.ivld), 1);
        en = 1'b0;
        bus.ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("t4_stall_ivld", 32'(bus.ivld), 1);
            chk("t4_stall_inum", 32'(bus.inum), 1);
            chk("t4_stall_isr", 32'(bus.isr), 0);
        end
        en = 1'b1;
        bus.eret = 1'b1;
        cyc(1);
        bus.ack = 1'b0;
        bus.eret = 1'b0;
        chk("t4_ack_eret_isr", 32'(bus.isr), 32'b010);
        chk("t4_ack_eret_pend", 32'(bus.pending), 0);
        chk("t4_ack_eret_ivld", 32'(bus.ivld), 0);
        bus.eret = 1'b1;
        cyc(1);
        bus.eret = 1'b0;
        chk("t4_isr_done", 32'(bus.isr), 0);
        // 5: higher-priority edge while serving src0
        sb.push_back('{"t5_src0", 2'd0});
        pulse(3'b001);
        cyc(3);
        bus.ack = 1'b1;
        cyc(1);
        bus.ack = 1'b0;
        chk("t5_isr0", 32'(bus.isr), 32'b001);
`ifdef IRQ_NEST_EN
        sb.push_back('{"t5_nest", 2'd2});
`endif
        pulse(3'b100);
        cyc(2);
        chk("t5_pending", 32'(bus.pending), 32'b100);
        cyc(1);
`ifdef IRQ_NEST_EN
        chk("t5_nest_ivld", 32'(bus.ivld), 1);
        chk("t5_nest_isr", 32'(bus.isr), 32'b001);
        bus.ack = 1'b1;
        cyc(1);
        bus.ack = 1'b0;
        chk("t5_nest_isr_ack", 32'(bus.isr), 32'b101);
        chk("t5_nest_pend_ack", 32'(bus.pending), 0);
        bus.eret = 1'b1;
        cyc(1);
        bus.eret = 1'b0;
        chk("t5_pop_isr", 32'(bus.isr), 32'b001);
        chk("t5_pop_busy", 32'(bus.busy), 1);
        chk("t5_pop_ivld", 32'(bus.ivld), 0);
        bus.eret = 1'b1;
        cyc(1);
        bus.eret = 1'b0;
        chk("t5_isr_done", 32'(bus.isr), 0);
`else
        chk("t5_nonest_ivld", 32'(bus.ivld), 0);
        chk("t5_nonest_isr", 32'(bus.isr), 32'b001);
        sb.push_back('{"t5_after", 2'd2});
        bus.eret = 1'b1;
        cyc(1);
        bus.eret = 1'b0;
        chk("t5_isr_eret", 32'(bus.isr), 0);
        cyc(1);
        chk("t5_ivld_after", 32'(bus.ivld), 1);
        bus.ack = 1'b1;
        cyc(1);
        bus.ack = 1'b0;
        bus.eret = 1'b1;
        cyc(1);
        bus.eret = 1'b0;
        chk("t5_isr_done", 32'(bus.isr), 0);
`endif
        // 6: asynchronous reset while serving with edges pending and in flight
        sb.push_back('{"t6_src2", 2'd2});
        pulse(3'b100);
        cyc(3);
        bus.ack = 1'b1;
        cyc(1);
        bus.ack = 1'b0;
        chk("t6_isr", 32'(bus.isr), 32'b100);
        pulse(3'b011);
        cyc(2);
        chk("t6_pending", 32'(bus.pending), 32'b011);
        chk("t6_ivld", 32'(bus.ivld), 0);
        irq_src = 3'b100;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_ivld", 32'(bus.ivld), 0);
        chk("t6_rst_pending", 32'(bus.pending), 0);
        chk("t6_rst_isr", 32'(bus.isr), 0);
        chk("t6_rst_busy", 32'(bus.busy), 0);
        chk("t6_rst_inum", 32'(bus.inum), 0);
        irq_src = '0;
        cyc(3);
        rst_n = 1'b1;
        cyc(6);
        chk("t6_post_pending", 32'(bus.pending), 0);
        chk("t6_post_ivld", 32'(bus.ivld), 0);
        sb.push_back('{"t6_new", 2'd1});
        pulse(3'b010);
        cyc(3);
        chk("t6_new_ivld", 32'(bus.ivld), 1);
        cyc(2);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
